jt12_lfo_gen: RTL
=================

JT12_LFO_GEN -- requirements
Module: jt12_lfo_gen

Interface
REQ-001 The block SHALL have exactly one clock and the port list SHALL start with clk and rst_n. Reset is synchronous and active-low.
REQ-002 Port: clk, input, 1, system clock.
REQ-003 Port: rst_n, input, 1, synchronous active-low reset.
REQ-004 Port: cen, input, 1, clock enable; all state SHALL hold when cen=0.
REQ-005 Port: zero, input, 1, one-clock pulse marking the start of each 24-slot sample cycle; it SHALL count only when cen=1.
REQ-006 Port: lfo_en, input, 1, LFO enable bit from register 0x22.
REQ-007 Port: lfo_freq, input, 3, LFO rate select from register 0x22.
REQ-008 Port: lfo_mod, output, 7, registered LFO phase counter.
REQ-009 Port: pm_lfo, output, 5, lfo_mod[6:2]. Bit 4 is the sign, bit 3 is the fold, bits 2:0 are the index. This is the input to the downstream PM offset stage.
REQ-010 Port: am_lfo, output, 6, triangle amplitude value. It SHALL equal ~lfo_mod[5:0] when lfo_mod[6]=1, and lfo_mod[5:0] otherwise.
REQ-011 Port: lfo_step, output, 1, one-clock strobe on each lfo_mod increment.

Function
REQ-012 A qualified zero (zero=1 and cen=1) SHALL advance a 7-bit divider div.
REQ-013 The period table, indexed by lfo_freq 0..7, SHALL be 108, 77, 71, 67, 62, 44, 8, 5 samples per step.
REQ-014 On a qualified zero with div >= period-1: div SHALL load 0, lfo_mod SHALL increment by 1, and lfo_step SHALL be 1 for the next clock.
REQ-015 On a qualified zero with div < period-1: div SHALL increment, and lfo_mod SHALL hold.
REQ-016 lfo_mod SHALL wrap from 127 to 0 with no extra delay. The wrap step SHALL assert lfo_step like any other step.
REQ-017 The ">=" compare in REQ-014 SHALL make a mid-count lfo_freq change to a shorter period step on the next qualified zero, not wrap the divider.
REQ-018 When lfo_en=0 at a clock edge with cen=1, div and lfo_mod SHALL load 0 and lfo_step SHALL load 0, whether or not zero is asserted. Disable SHALL take priority over a simultaneous step.
REQ-019 After lfo_en rises, counting SHALL restart from div=0 and lfo_mod=0. The first step SHALL occur on the period-th qualified zero.
REQ-020 lfo_step SHALL be 0 on every clock except the one following a step. With cen=0, lfo_step SHALL be forced to 0.
REQ-021 pm_lfo and am_lfo SHALL be combinational from the registered lfo_mod, with zero added latency.
REQ-022 zero pulses with cen=0 SHALL be ignored, not queued.

Reset
REQ-023 With rst_n=0 at a clock edge, div SHALL load 0, lfo_mod SHALL load 0 and lfo_step SHALL load 0, regardless of cen.
REQ-024 During reset, pm_lfo SHALL read 0 and am_lfo SHALL read 0.
REQ-025 A reset mid-period SHALL discard the partial divider count. The first step after release SHALL need a full period.

Structure
REQ-026 The 8-entry period table and the 7-bit widths of div and lfo_mod SHALL be defined as constants in the shared package jt12_lfo_pkg.
REQ-027 The divider (div, compare, step strobe) SHALL be the sub-module jt12_lfo_div.
REQ-028 The lfo_mod register and the pm/am derivation SHALL stay in jt12_lfo_gen.
REQ-029 The block SHALL contain no latches and no clock gating; cen SHALL act only as an enable.

Verification
REQ-030 lfo_en=1, lfo_freq=7, cen=1, 5 zero pulses: lfo_mod 0->1 after the 5th pulse, one lfo_step pulse. 640 pulses: lfo_mod wraps to 0, exactly 128 steps.
REQ-031 lfo_freq=0, lfo_en=1: lfo_mod=1 after the 108th qualified zero. lfo_freq set to 6 when div=50: step on the next qualified zero.
REQ-032 lfo_mod=0x47 (bit6=1, [5:0]=0x07): am_lfo=0x38 and pm_lfo=0x11.
REQ-033 lfo_en dropped on the same clock as a step-causing zero: lfo_mod=0 and no lfo_step. lfo_en raised again: first step after period pulses.
REQ-034 zero pulses with cen=0 interleaved with qualified ones: only the qualified pulses count. lfo_freq=7 needs 5 qualified pulses to step.
REQ-035 rst_n=0 for one clock when lfo_mod=0x20 and div=3: all outputs 0 the next clock. The first step needs a full period after release.

Source files
------------

// File: rtl/jt12_lfo_pkg.sv
// ============================================================================
// jt12_lfo_pkg : shared LFO widths and rate table      rev 1.0
// ============================================================================
`default_nettype none

package jt12_lfo_pkg;

  localparam int LFO_DIV_W = 7;
  localparam int LFO_MOD_W = 7;

  // Samples per LFO step, indexed by lfo_freq (entry 0 is the rightmost).
  localparam logic [7:0][LFO_DIV_W-1:0] LFO_PERIOD = {
    7'd5, 7'd8, 7'd44, 7'd62, 7'd67, 7'd71, 7'd77, 7'd108
  };

  function automatic logic [LFO_DIV_W-1:0] lfo_period_m1(input logic [2:0] freq);
    return LFO_PERIOD[freq] - LFO_DIV_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt12_lfo_div.sv
// ============================================================================
// jt12_lfo_div : sample divider producing the LFO advance and step strobe  rev 1.0
// ============================================================================
`default_nettype none

module jt12_lfo_div
  import jt12_lfo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       lfo_en,
  input  logic [2:0] lfo_freq,
  output logic       inc,
  output logic       lfo_step
);

  logic [LFO_DIV_W-1:0] div_d, div_q;
  logic                 step_d, step_q;

  // ">=" lets a shortened period fire on the next sample instead of wrapping.
  always_comb begin
    div_d  = div_q;
    step_d = 1'b0;
    inc    = 1'b0;
    if (cen) begin
      if (!lfo_en) begin
        div_d = '0;
      end else if (zero) begin
        if (div_q >= lfo_period_m1(lfo_freq)) begin
          div_d  = '0;
          inc    = 1'b1;
          step_d = 1'b1;
        end else begin
          div_d = div_q + LFO_DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
    end
  end

  assign lfo_step = step_q;

endmodule

`default_nettype wire

// File: rtl/jt12_lfo_gen.sv
// ============================================================================
// jt12_lfo_gen : YM2612 LFO phase counter with PM/AM derivation   rev 1.0
// ============================================================================
`default_nettype none

module jt12_lfo_gen
  import jt12_lfo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 zero,
  input  logic                 lfo_en,
  input  logic [2:0]           lfo_freq,
  output logic [LFO_MOD_W-1:0] lfo_mod,
  output logic [4:0]           pm_lfo,
  output logic [5:0]           am_lfo,
  output logic                 lfo_step
);

  logic                 inc;
  logic [LFO_MOD_W-1:0] lfo_mod_d, lfo_mod_q;

  jt12_lfo_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .zero     (zero),
    .lfo_en   (lfo_en),
    .lfo_freq (lfo_freq),
    .inc      (inc),
    .lfo_step (lfo_step)
  );

  // Natural 7-bit overflow gives the 127 -> 0 wrap.
  always_comb begin
    lfo_mod_d = lfo_mod_q;
    if (cen && !lfo_en) begin
      lfo_mod_d = '0;
    end else if (inc) begin
      lfo_mod_d = lfo_mod_q + LFO_MOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfo_mod_q <= '0;
    end else begin
      lfo_mod_q <= lfo_mod_d;
    end
  end

  assign lfo_mod = lfo_mod_q;
  assign pm_lfo  = lfo_mod_q[6:2];
  assign am_lfo  = lfo_mod_q[6] ? ~lfo_mod_q[5:0] : lfo_mod_q[5:0];

endmodule

`default_nettype wire
